// File: rtl/cw_sequencer_if.sv
// rtl/cw_sequencer_if.sv - decoder/datapath-side signal bundle of the control-word sequencer
//
// Purpose: groups every non-clock, non-reset signal of cw_sequencer.
// Ports (slave view = the sequencer):
//   in : stall, instr_in[31:0], status_in[4:0], cw_in[32:0]
//   out: cur_instr[31:0], state[1:0], status[4:0], cw_out[32:0],
//        retire, retired_count[CNT_W-1:0], halted, error
interface cw_sequencer_if #(
  parameter int CNT_W = 32
);
  logic             stall;
  logic [31:0]      instr_in;
  logic [4:0]       status_in;
  logic [32:0]      cw_in;
  logic [31:0]      cur_instr;
  logic [1:0]       state;
  logic [4:0]       status;
  logic [32:0]      cw_out;
  logic             retire;
  logic [CNT_W-1:0] retired_count;
  logic             halted;
  logic             error;

  modport master (
    output stall, instr_in, status_in, cw_in,
    input  cur_instr, state, status, cw_out, retire, retired_count, halted, error
  );

  modport slave (
    input  stall, instr_in, status_in, cw_in,
    output cur_instr, state, status, cw_out, retire, retired_count, halted, error
  );
endinterface

// File: rtl/cw_sequencer.sv
// rtl/cw_sequencer.sv - multicycle control sequencer with control-word gating
//
// Purpose: holds the sequencer state, instruction and status registers,
// forwards the decoder control word to the datapath with its side effects
// suppressed during stall/halt/reset, counts retired instructions and flags
// illegal next-state encodings.
// Ports:
//   clock - rising-edge clock
//   reset - synchronous active-high reset
//   bus   - cw_sequencer_if.slave (see interface file for the signal list)
//
// Control-word layout: [32] alu_en [31] alu_bs [30:26] alu_fs [25] rf_b_en
// [24:20] rf_sa [19:15] rf_sb [14:10] rf_da [9] rf_w [8] ram_en [7] ram_w
// [6] pc_en [5:4] pc_fs [3] pc_is [2] status_ld [1:0] next_state
module cw_sequencer #(
  parameter int CNT_W = 32
) (
  input  logic          clock,
  input  logic          reset,
  cw_sequencer_if.slave bus
);

  localparam int B_RF_W      = 9;
  localparam int B_RAM_W     = 7;
  localparam int B_STATUS_LD = 2;

  logic [1:0]       state_q;
  logic [31:0]      ir_q;
  logic [4:0]       status_q;
  logic [CNT_W-1:0] count_q;
  logic             retire_q;
  logic             halted_q;
  logic             error_q;

  logic       active;
  logic       halt_hit;
  logic       go;
  logic [1:0] next_st;
  logic       illegal;

  always_comb begin
    active   = !reset && !bus.stall && !halted_q;
    // An all-zero fetch is a halt: the cycle is treated as a no-op, so it
    // neither sequences nor retires.
    halt_hit = active && (state_q == 2'b00) && (bus.instr_in == 32'h0000_0000);
    go       = active && !halt_hit;
    next_st  = bus.cw_in[1:0];
    illegal  = (next_st == 2'b11);
  end

  always_comb begin
    bus.cw_out = bus.cw_in;
    if (!go) begin
      bus.cw_out[B_RF_W]      = 1'b0;
      bus.cw_out[B_RAM_W]     = 1'b0;
      bus.cw_out[B_STATUS_LD] = 1'b0;
      bus.cw_out[5:4]         = 2'b00;
      bus.cw_out[1:0]         = state_q;
    end
  end

  assign bus.cur_instr     = (state_q == 2'b00) ? bus.instr_in : ir_q;
  assign bus.state         = state_q;
  assign bus.status        = status_q;
  assign bus.retire        = retire_q;
  assign bus.retired_count = count_q;
  assign bus.halted        = halted_q;
  assign bus.error         = error_q;

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q  <= 2'b00;
      ir_q     <= 32'h0000_0000;
      status_q <= 5'b00000;
      count_q  <= '0;
      retire_q <= 1'b0;
      halted_q <= 1'b0;
      error_q  <= 1'b0;
    end else begin
      retire_q <= 1'b0;
      if (halt_hit) begin
        halted_q <= 1'b1;
      end
      if (go) begin
        if (state_q == 2'b00) begin
          ir_q <= bus.instr_in;
        end
        if (bus.cw_in[B_STATUS_LD]) begin
          status_q <= bus.status_in;
        end
        // Illegal encoding collapses to the fetch state and still retires.
        if (illegal) begin
          state_q <= 2'b00;
          error_q <= 1'b1;
        end else begin
          state_q <= next_st;
        end
        if (illegal || next_st == 2'b00) begin
          retire_q <= 1'b1;
          count_q  <= count_q + CNT_W'(1);
        end
      end
    end
  end

endmodule

// File: tb/tb_cw_sequencer.sv
// tb/tb_cw_sequencer.sv - scoreboard bench for cw_sequencer
module tb_cw_sequencer;

  localparam int CNT_W = 4;

  typedef struct packed {
    logic [32:0]      cw;
    logic [31:0]      ci;
    logic [1:0]       st;
    logic [4:0]       ss;
    logic             ret;
    logic [CNT_W-1:0] cnt;
    logic             h;
    logic             e;
  } exp_t;

  logic clock = 1'b0;
  logic reset = 1'b1;

  cw_sequencer_if #(.CNT_W(CNT_W)) bus ();

  cw_sequencer #(.CNT_W(CNT_W)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clock = ~clock;

  exp_t exp_q[$];
  int   vectors = 0;
  int   miscompares = 0;

  // Reference model state (plain integers, behavioural)
  int          m_state;
  logic [31:0] m_ir;
  logic [4:0]  m_status;
  int          m_count;
  bit          m_retire;
  bit          m_halted;
  bit          m_error;

  task automatic model_reset();
    m_state = 0; m_ir = 0; m_status = 0; m_count = 0;
    m_retire = 0; m_halted = 0; m_error = 0;
  endtask

  // One clock cycle: apply inputs, queue the expected observation, advance the model.
  task automatic cyc(input bit rst, input bit stl, input logic [31:0] instr,
                     input logic [4:0] stin, input logic [32:0] cw);
    exp_t e;
    bit   is_halt, does_work;
    int   nxt;
    @(posedge clock);
    #1;
    reset         = rst;
    bus.stall     = stl;
    bus.instr_in  = instr;
    bus.status_in = stin;
    bus.cw_in     = cw;

    is_halt   = !rst && !stl && !m_halted && m_state == 0 && instr == 0;
    does_work = !rst && !stl && !m_halted && !is_halt;

    e.cw = cw;
    if (!does_work) begin
      e.cw[9]   = 1'b0;
      e.cw[7]   = 1'b0;
      e.cw[2]   = 1'b0;
      e.cw[5:4] = 2'b00;
      e.cw[1:0] = 2'(m_state);
    end
    e.ci  = (m_state == 0) ? instr : m_ir;
    e.st  = 2'(m_state);
    e.ss  = m_status;
    e.ret = m_retire;
    e.cnt = CNT_W'(m_count);
    e.h   = m_halted;
    e.e   = m_error;
    exp_q.push_back(e);

    if (rst) begin
      model_reset();
    end else begin
      m_retire = 0;
      if (is_halt) m_halted = 1;
      if (does_work) begin
        nxt = int'(cw[1:0]);
        if (m_state == 0) m_ir = instr;
        if (cw[2]) m_status = stin;
        if (nxt == 3) begin
          m_error = 1;
          nxt = 0;
        end
        m_state = nxt;
        if (nxt == 0) begin
          m_retire = 1;
          m_count  = (m_count + 1) % (1 << CNT_W);
        end
      end
    end
  endtask

  // Monitor: compares whatever the DUT presents mid-cycle against the queue head.
  always @(negedge clock) begin
    exp_t e;
    exp_t a;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      a.cw  = bus.cw_out;
      a.ci  = bus.cur_instr;
      a.st  = bus.state;
      a.ss  = bus.status;
      a.ret = bus.retire;
      a.cnt = bus.retired_count;
      a.h   = bus.halted;
      a.e   = bus.error;
      vectors++;
      if (a !== e) begin
        miscompares++;
        $display("FAIL vec%0d: got cw=%h ci=%h st=%0d ss=%b ret=%b cnt=%0d h=%b e=%b want cw=%h ci=%h st=%0d ss=%b ret=%b cnt=%0d h=%b e=%b",
                 vectors, a.cw, a.ci, a.st, a.ss, a.ret, a.cnt, a.h, a.e,
                 e.cw, e.ci, e.st, e.ss, e.ret, e.cnt, e.h, e.e);
      end
    end
  end

  function automatic logic [32:0] rcw(input logic [1:0] ns);
    logic [32:0] c;
    c = {1'($urandom), 32'($urandom)};
    c[1:0] = ns;
    return c;
  endfunction

  function automatic logic [1:0] rnd_ns();
    int r;
    r = $urandom_range(0, 19);
    if (r < 10) return 2'b00;
    if (r < 16) return 2'b01;
    if (r < 19) return 2'b10;
    return 2'b11;
  endfunction

  initial begin
    logic [32:0] ones;
    logic [32:0] c;
    logic [31:0] ins;
    ones = '1;
    reset = 1'b1;
    bus.stall = 1'b0;
    bus.instr_in = 32'h0;
    bus.status_in = 5'h0;
    bus.cw_in = ones;
    @(posedge clock);
    model_reset();

    // Reset held with an all-ones control word
    cyc(1, 0, 32'hFFFF_FFFF, 5'h1F, ones);
    cyc(1, 0, 32'hFFFF_FFFF, 5'h1F, ones);

    // Two-cycle instruction, IR stable while instr_in changes
    cyc(0, 0, 32'hF2A1_2345, 5'h00, rcw(2'b01));
    cyc(0, 0, 32'h1234_5678, 5'h00, rcw(2'b00));
    cyc(0, 0, 32'h1234_5678, 5'h00, {31'h0, 2'b01});

    // Stall three cycles in state 01, with rf_w/pc_fs requested
    c = rcw(2'b00); c[9] = 1'b1; c[5:4] = 2'b11;
    repeat (3) cyc(0, 1, 32'hDEAD_BEEF, 5'h0A, c);
    cyc(0, 0, 32'hDEAD_BEEF, 5'h0A, c);
    cyc(0, 0, 32'h0BAD_F00D, 5'h00, {31'h0, 2'b00});

    // Status load active, then requested under stall
    c = rcw(2'b00); c[2] = 1'b1;
    cyc(0, 0, 32'h0000_1111, 5'b10110, c);
    cyc(0, 1, 32'h0000_2222, 5'b01001, c);
    cyc(0, 0, 32'h0000_3333, 5'b00000, {31'h0, 2'b00});

    // Illegal next state, then halt and ignored instructions
    cyc(0, 0, 32'h0000_4444, 5'h00, rcw(2'b11));
    cyc(0, 0, 32'h0000_5555, 5'h00, rcw(2'b00));
    cyc(0, 0, 32'h0000_0000, 5'h00, ones);
    repeat (3) cyc(0, 0, 32'h0000_6666, 5'h1F, ones);

    // Counter wrap: 17 single-cycle instructions after reset
    cyc(1, 0, 32'h0, 5'h0, ones);
    repeat (17) cyc(0, 0, 32'h8000_0001, 5'h00, rcw(2'b00));
    cyc(0, 0, 32'h8000_0001, 5'h00, rcw(2'b01));

    // Randomized traffic
    for (int i = 0; i < 2000; i++) begin
      ins = $urandom;
      if ($urandom_range(0, 79) == 0) ins = 32'h0;
      cyc(($urandom_range(0, 59) == 0), ($urandom_range(0, 3) == 0),
          ins, 5'($urandom), rcw(rnd_ns()));
    end

    repeat (3) @(negedge clock);
    if (exp_q.size() != 0) begin
      miscompares++;
      $display("FAIL drain: %0d expected vectors left, want 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
